// File: rtl/decode_output_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_output_queue
// Description : In-order FIFO of packed decoded-instruction payloads sitting
//               between the format-specific decoders and the issue stage.
//               Valid/stall handshake on both sides, single-cycle flush for
//               branch redirects.
// Options     : DECODE_QUEUE_OVERFLOW_CHECK_EN - when defined, overflow_o is
//               a sticky flag set by any push attempt while the queue is
//               full; otherwise overflow_o is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_output_queue #(
  parameter int payloadWidth = 220,
  parameter int queueDepth   = 4,
  parameter int ptrWidth     = 2
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    enable_i,
  input  logic [payloadWidth-1:0] payload_i,
  output logic                    stall_o,
  input  logic                    stall_i,
  output logic                    enable_o,
  output logic [payloadWidth-1:0] payload_o,
  output logic [ptrWidth:0]       count_o,
  output logic                    overflow_o
);

  localparam logic [ptrWidth:0]   c_depth   = (ptrWidth+1)'(queueDepth);
  localparam logic [ptrWidth:0]   c_cnt_one = (ptrWidth+1)'(1);
  localparam logic [ptrWidth-1:0] c_ptr_one = ptrWidth'(1);

  // Storage is deliberately left unreset; only the pointers define validity.
  logic [payloadWidth-1:0] r_mem [queueDepth];
  logic [ptrWidth-1:0]     r_wp;
  logic [ptrWidth-1:0]     r_rp;
  logic [ptrWidth:0]       r_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full/empty come from registered occupancy only, so a same-cycle pop never
  // makes room for a push into a full queue. Flush suppresses both sides.
  assign w_full  = (r_cnt == c_depth);
  assign w_empty = (r_cnt == '0);
  assign w_push  = enable_i & ~w_full & ~flush_i;
  assign w_pop   = ~w_empty & ~stall_i & ~flush_i;

  // Write accepted payloads into the slot at the write pointer.
  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_mem[r_wp] <= payload_i;
    end
  end

  // Pointer and occupancy tracking; flush returns everything to empty.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + c_ptr_one;
      end
      if (w_pop) begin
        r_rp <= r_rp + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_cnt_one;
        2'b01:   r_cnt <= r_cnt - c_cnt_one;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign enable_o  = ~w_empty;
  assign stall_o   = w_full;
  assign count_o   = r_cnt;
  assign payload_o = r_mem[r_rp];

`ifdef DECODE_QUEUE_OVERFLOW_CHECK_EN
  logic r_overflow;

  // Sticky error flag: any push attempt into a full queue; only reset clears it.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_overflow <= 1'b0;
    end else if (enable_i & w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;
`else
  assign overflow_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_output_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_output_queue
// Description : Self-checking bench for decode_output_queue. Directed
//               scenarios plus a randomized run against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_output_queue;

  localparam int W      = 220;
  localparam int D      = 4;
  localparam int MAJ_HI = 140;
  localparam int MAJ_LO = 77;

`ifdef DECODE_QUEUE_OVERFLOW_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_i;
  logic         en_i;
  logic [W-1:0] pay_i;
  logic         stall_o;
  logic         stall_i;
  logic         en_o;
  logic [W-1:0] pay_o;
  logic [2:0]   cnt_o;
  logic         ovf_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents in order, plus sticky overflow flag.
  logic [W-1:0] mq[$];
  bit           m_ovf;

  always #5 clk = ~clk;

  decode_output_queue #(
    .payloadWidth(W),
    .queueDepth  (D),
    .ptrWidth    (2)
  ) dut (
    .clock_i   (clk),
    .reset_i   (rst_n),
    .flush_i   (flush_i),
    .enable_i  (en_i),
    .payload_i (pay_i),
    .stall_o   (stall_o),
    .stall_i   (stall_i),
    .enable_o  (en_o),
    .payload_o (pay_o),
    .count_o   (cnt_o),
    .overflow_o(ovf_o)
  );

  function automatic logic [W-1:0] mk(input logic [63:0] maj);
    logic [W-1:0] p;
    p = W'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    p[MAJ_HI:MAJ_LO] = maj;
    return p;
  endfunction

  function automatic logic [63:0] maj_of(input logic [W-1:0] p);
    return p[MAJ_HI:MAJ_LO];
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle past it.
  task automatic tick(input bit fl, input bit en, input bit st, input logic [W-1:0] p);
    bit push_ok;
    bit pop_ok;
    flush_i = fl;
    en_i    = en;
    stall_i = st;
    pay_i   = p;
    @(posedge clk);
    if (OVF_EN && en && mq.size() == D) m_ovf = 1'b1;
    if (fl) begin
      mq.delete();
    end else begin
      push_ok = en && (mq.size() != D);
      pop_ok  = (mq.size() != 0) && !st;
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(p);
    end
    #1;
    en_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 0; en_i = 0; stall_i = 1; pay_i = '0;
    mq.delete(); m_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %0b expected 0", en_o); end
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", stall_o); end
    n_tests++; if (cnt_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt_o); end
    n_tests++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", ovf_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int k = 1; k <= 4; k++) tick(0, 1, 1, mk(64'(k)));
    n_tests++; if (cnt_o !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", cnt_o); end
    n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL fill_stall: got %0b expected 1", stall_o); end
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if (en_o !== 1'b1 || maj_of(pay_o) !== 64'(k)) begin
        n_fail++; $display("FAIL drain_head: got en=%0b maj=%0d expected en=1 maj=%0d", en_o, maj_of(pay_o), k);
      end
      tick(0, 0, 0, '0);
    end
    n_tests++; if (en_o !== 1'b0 || cnt_o !== 3'd0) begin
      n_fail++; $display("FAIL drain_empty: got en=%0b cnt=%0d expected en=0 cnt=0", en_o, cnt_o);
    end
  endtask

  task automatic test_streaming();
    tick(0, 1, 1, mk(64'd10));
    tick(0, 1, 1, mk(64'd11));
    for (int m = 12; m <= 30; m++) begin
      n_tests++;
      if (cnt_o !== 3'd2 || maj_of(pay_o) !== 64'(m - 2)) begin
        n_fail++; $display("FAIL stream_head: got cnt=%0d maj=%0d expected cnt=2 maj=%0d", cnt_o, maj_of(pay_o), m - 2);
      end
      tick(0, 1, 0, mk(64'(m)));
    end
    for (int m = 29; m <= 30; m++) begin
      n_tests++;
      if (en_o !== 1'b1 || maj_of(pay_o) !== 64'(m)) begin
        n_fail++; $display("FAIL stream_tail: got en=%0b maj=%0d expected en=1 maj=%0d", en_o, maj_of(pay_o), m);
      end
      tick(0, 0, 0, '0);
    end
    n_tests++; if (cnt_o !== 3'd0) begin n_fail++; $display("FAIL stream_empty: got %0d expected 0", cnt_o); end
  endtask

  task automatic test_push_full();
    for (int k = 40; k <= 43; k++) tick(0, 1, 1, mk(64'(k)));
    tick(0, 1, 1, mk(64'd99));
    n_tests++; if (cnt_o !== 3'd4) begin n_fail++; $display("FAIL full_push_count: got %0d expected 4", cnt_o); end
    n_tests++; if (ovf_o !== OVF_EN) begin n_fail++; $display("FAIL full_push_overflow: got %0b expected %0b", ovf_o, OVF_EN); end
    for (int k = 40; k <= 43; k++) begin
      n_tests++;
      if (en_o !== 1'b1 || maj_of(pay_o) !== 64'(k)) begin
        n_fail++; $display("FAIL full_push_drain: got en=%0b maj=%0d expected en=1 maj=%0d", en_o, maj_of(pay_o), k);
      end
      tick(0, 0, 0, '0);
    end
    n_tests++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL full_push_dropped: got en=%0b expected 0", en_o); end
  endtask

  task automatic test_full_pop_push();
    for (int k = 50; k <= 53; k++) tick(0, 1, 1, mk(64'(k)));
    tick(0, 1, 0, mk(64'd54));
    n_tests++; if (cnt_o !== 3'd3) begin n_fail++; $display("FAIL fullpp_count: got %0d expected 3", cnt_o); end
    for (int k = 51; k <= 53; k++) begin
      n_tests++;
      if (en_o !== 1'b1 || maj_of(pay_o) !== 64'(k)) begin
        n_fail++; $display("FAIL fullpp_drain: got en=%0b maj=%0d expected en=1 maj=%0d", en_o, maj_of(pay_o), k);
      end
      tick(0, 0, 0, '0);
    end
    n_tests++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL fullpp_rejected: got en=%0b expected 0", en_o); end
  endtask

  task automatic test_flush();
    for (int k = 60; k <= 62; k++) tick(0, 1, 1, mk(64'(k)));
    tick(1, 1, 1, mk(64'd55));
    n_tests++; if (cnt_o !== 3'd0 || en_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_state: got cnt=%0d en=%0b expected cnt=0 en=0", cnt_o, en_o);
    end
    tick(0, 1, 1, mk(64'd56));
    n_tests++; if (en_o !== 1'b1 || cnt_o !== 3'd1 || maj_of(pay_o) !== 64'd56) begin
      n_fail++; $display("FAIL flush_next: got en=%0b cnt=%0d maj=%0d expected en=1 cnt=1 maj=56", en_o, cnt_o, maj_of(pay_o));
    end
    tick(0, 0, 0, '0);
  endtask

  task automatic test_async_reset();
    tick(0, 1, 1, mk(64'd70));
    tick(0, 1, 1, mk(64'd71));
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (en_o !== 1'b0 || cnt_o !== 3'd0 || stall_o !== 1'b0 || ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got en=%0b cnt=%0d stall=%0b ovf=%0b expected all 0", en_o, cnt_o, stall_o, ovf_o);
    end
    mq.delete(); m_ovf = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(0, 1, 1, mk(64'd72));
    n_tests++; if (en_o !== 1'b1 || cnt_o !== 3'd1 || maj_of(pay_o) !== 64'd72) begin
      n_fail++; $display("FAIL post_reset_push: got en=%0b cnt=%0d maj=%0d expected en=1 cnt=1 maj=72", en_o, cnt_o, maj_of(pay_o));
    end
    tick(0, 0, 0, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 25) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0, mk(64'($urandom)));
      n_tests++;
      if (en_o !== (mq.size() != 0) || cnt_o !== 3'(mq.size()) || stall_o !== (mq.size() == D) || ovf_o !== m_ovf) begin
        n_fail++; $display("FAIL rand_status cyc %0d: got en=%0b cnt=%0d stall=%0b ovf=%0b expected cnt=%0d ovf=%0b",
                           i, en_o, cnt_o, stall_o, ovf_o, mq.size(), m_ovf);
      end
      if (mq.size() != 0) begin
        n_tests++;
        if (pay_o !== mq[0]) begin
          n_fail++; $display("FAIL rand_payload cyc %0d: got %h expected %h", i, pay_o, mq[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_push_full();
    test_full_pop_push();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
